// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display sharing logic.
package ssd_pkg;

    localparam int SSD_VAL_W  = 32;
    localparam int SSD_DIGITS = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BLANK = 2'd1,
        ARB_OWN   = 2'd2
    } ssd_arb_state_t;

endpackage

// File: rtl/ssd_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of mask_i
// scanning base_i+1, base_i+2, ... (mod N_REQ). base_i itself is scanned last.
module ssd_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         mask_i,
    input  logic [$clog2(N_REQ)-1:0] base_i,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] cand_s;

    // Scan farthest candidate first so the nearest set bit overwrites it last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = {IDX_W{1'b0}};
        cand_s  = {IDX_W{1'b0}};
        for (int k = N_REQ; k >= 1; k--) begin
            cand_s  = IDX_W'((int'(base_i) + k) % N_REQ);
            valid_o = valid_o | mask_i[cand_s];
            idx_o   = mask_i[cand_s] ? cand_s : idx_o;
        end
    end

endmodule

// File: rtl/ssd_share_arbiter.sv
// Shares one 8-digit seven-segment display between N_REQ requesters with
// round-robin ownership, a minimum dwell per owner and a blanking gap
// between owners. All outputs are registered.
module ssd_share_arbiter
    import ssd_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 100000000,
    parameter int BLANK_CYCLES = 10000000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [N_REQ-1:0]           req_in,
    input  logic [N_REQ-1:0]           upd_in,
    input  logic [SSD_VAL_W*N_REQ-1:0] val_in,
    output logic [N_REQ-1:0]           grant_out,
    output logic [$clog2(N_REQ)-1:0]   owner_out,
    output logic [SSD_VAL_W-1:0]       val_out,
    output logic                       blank_out
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(DWELL_CYCLES);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_REQ - 1);

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    ssd_arb_state_t       state_q,      state_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic [IDX_W-1:0]     pend_q,       pend_d;
    logic [IDX_W-1:0]     owner_q,      owner_d;
    logic [SSD_VAL_W-1:0] val_q,        val_d;
    logic [N_REQ-1:0]     grant_q,      grant_d;
    logic                 blank_q,      blank_d;
    logic [BLANK_W-1:0]   blank_cnt_q,  blank_cnt_d;
    logic [DWELL_W-1:0]   dwell_cnt_q,  dwell_cnt_d;

    logic [N_REQ-1:0]     others_s;
    logic [N_REQ-1:0]     pick_mask_s;
    logic [IDX_W-1:0]     pick_base_s;
    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_idx_s;

    // One shared picker; its inputs depend on which state is asking.
    always_comb begin
        others_s    = req_in & ~onehot(owner_q);
        pick_mask_s = req_in;
        pick_base_s = last_owner_q;
        case (state_q)
            ARB_IDLE: begin
                pick_mask_s = req_in;
                pick_base_s = last_owner_q;
            end
            ARB_BLANK: begin
                pick_mask_s = req_in;
                pick_base_s = pend_q;
            end
            ARB_OWN: begin
                // On release req_in[owner] is 0, so others equals req_in there.
                pick_mask_s = others_s;
                pick_base_s = owner_q;
            end
            default: begin
                pick_mask_s = req_in;
                pick_base_s = last_owner_q;
            end
        endcase
    end

    ssd_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .mask_i  (pick_mask_s),
        .base_i  (pick_base_s),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        pend_d       = pend_q;
        owner_d      = owner_q;
        val_d        = val_q;
        grant_d      = grant_q;
        blank_d      = blank_q;
        blank_cnt_d  = blank_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                grant_d = {N_REQ{1'b0}};
                blank_d = 1'b1;
                if (|req_in) begin
                    state_d     = ARB_BLANK;
                    pend_d      = pick_idx_s;
                    blank_cnt_d = {BLANK_W{1'b0}};
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BLANK: begin
                grant_d = {N_REQ{1'b0}};
                blank_d = 1'b1;
                if (blank_cnt_q == BLANK_LAST) begin
                    if (req_in[pend_q]) begin
                        state_d     = ARB_OWN;
                        owner_d     = pend_q;
                        val_d       = val_in[int'(pend_q)*SSD_VAL_W +: SSD_VAL_W];
                        dwell_cnt_d = {DWELL_W{1'b0}};
                        grant_d     = onehot(pend_q);
                        blank_d     = 1'b0;
                    end else if (pick_valid_s) begin
                        // Pending requester went away: re-pick and restart the gap.
                        pend_d      = pick_idx_s;
                        blank_cnt_d = {BLANK_W{1'b0}};
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    blank_cnt_d = blank_cnt_q + {{(BLANK_W-1){1'b0}}, 1'b1};
                end
            end
            ARB_OWN: begin
                if (dwell_cnt_q != DWELL_MAX) begin
                    dwell_cnt_d = dwell_cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
                end else begin
                    dwell_cnt_d = dwell_cnt_q;
                end
                if (!req_in[owner_q] ||
                    ((dwell_cnt_q == DWELL_MAX) && pick_valid_s)) begin
                    // Release (checked first) or preemption: both leave OWN.
                    last_owner_d = owner_q;
                    grant_d      = {N_REQ{1'b0}};
                    blank_d      = 1'b1;
                    if (pick_valid_s) begin
                        state_d     = ARB_BLANK;
                        pend_d      = pick_idx_s;
                        blank_cnt_d = {BLANK_W{1'b0}};
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (upd_in[owner_q]) begin
                    val_d = val_in[int'(owner_q)*SSD_VAL_W +: SSD_VAL_W];
                end else begin
                    val_d = val_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = {N_REQ{1'b0}};
                blank_d = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= IDX_LAST;
            pend_q       <= {IDX_W{1'b0}};
            owner_q      <= {IDX_W{1'b0}};
            val_q        <= {SSD_VAL_W{1'b0}};
            grant_q      <= {N_REQ{1'b0}};
            blank_q      <= 1'b1;
            blank_cnt_q  <= {BLANK_W{1'b0}};
            dwell_cnt_q  <= {DWELL_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            pend_q       <= pend_d;
            owner_q      <= owner_d;
            val_q        <= val_d;
            grant_q      <= grant_d;
            blank_q      <= blank_d;
            blank_cnt_q  <= blank_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
        end
    end

    assign grant_out = grant_q;
    assign owner_out = owner_q;
    assign val_out   = val_q;
    assign blank_out = blank_q;

endmodule

// File: tb/tb_ssd_share_arbiter.sv
// Directed self-checking bench for ssd_share_arbiter (N_REQ=4, DWELL=8, BLANK=2).
module tb_ssd_share_arbiter;

    logic         clk_s;
    logic         rst_s;
    logic [3:0]   req_s;
    logic [3:0]   upd_s;
    logic [127:0] val_s;
    logic [3:0]   grant_s;
    logic [1:0]   owner_s;
    logic [31:0]  valo_s;
    logic         blank_s;

    int n_cmp;
    int n_err;

    ssd_share_arbiter #(
        .N_REQ        (4),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_in    (clk_s),
        .rst_in    (rst_s),
        .req_in    (req_s),
        .upd_in    (upd_s),
        .val_in    (val_s),
        .grant_out (grant_s),
        .owner_out (owner_s),
        .val_out   (valo_s),
        .blank_out (blank_s)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock edge and settle 2 time units after it.
    task automatic tick();
        @(posedge clk_s);
        #2;
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "_grant"}, 64'(grant_s), 64'h0);
        check_eq({tag, "_blank"}, 64'(blank_s), 64'h1);
    endtask

    task automatic check_own(input string tag, input logic [3:0] g, input logic [1:0] o,
                             input logic [31:0] v);
        check_eq({tag, "_grant"}, 64'(grant_s), 64'(g));
        check_eq({tag, "_owner"}, 64'(owner_s), 64'(o));
        check_eq({tag, "_val"},   64'(valo_s),  64'(v));
        check_eq({tag, "_blank"}, 64'(blank_s), 64'h0);
    endtask

    initial begin
        int seg;
        int pos;
        logic [3:0] exp_g;
        n_cmp = 0;
        n_err = 0;
        rst_s = 1'b1;
        req_s = 4'b0000;
        upd_s = 4'b0000;
        val_s = 128'h0;
        #12;
        check_dark("rst");
        check_eq("rst_val",   64'(valo_s),  64'h0);
        check_eq("rst_owner", 64'(owner_s), 64'h0);
        rst_s = 1'b0;

        // Idle for five cycles with no requests.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_dark("idle");
            check_eq("idle_val",   64'(valo_s),  64'h0);
            check_eq("idle_owner", 64'(owner_s), 64'h0);
        end

        // Single requester 2: two blank cycles, then owner from the third edge.
        req_s = 4'b0100;
        val_s[64 +: 32] = 32'hDEADBEEF;
        tick();
        check_dark("lat1");
        tick();
        check_dark("lat2");
        tick();
        check_own("first", 4'b0100, 2'd2, 32'hDEADBEEF);

        // Requesters 0 and 2 alternate: 9 owned cycles, 2 blank, period 11.
        val_s[0 +: 32] = 32'hA0A0A0A0;
        req_s = 4'b0101;
        for (int c = 1; c <= 33; c++) begin
            tick();
            pos = c % 11;
            seg = (c + 2) / 11;
            if (pos == 9 || pos == 10) begin
                check_dark("rr_gap");
            end else begin
                exp_g = (seg % 2 == 0) ? 4'b0100 : 4'b0001;
                check_own("rr_own", exp_g, (seg % 2 == 0) ? 2'd2 : 2'd0,
                          (seg % 2 == 0) ? 32'hDEADBEEF : 32'hA0A0A0A0);
            end
        end

        // Owner 0 releases; requester 1 takes over after the gap.
        val_s[32 +: 32] = 32'h11111111;
        req_s = 4'b0010;
        tick();
        check_dark("rel_gap");
        tick();
        tick();
        check_own("own1", 4'b0010, 2'd1, 32'h11111111);

        // Owner update is taken; non-owner update is ignored.
        val_s[32 +: 32] = 32'h12345678;
        upd_s = 4'b0010;
        tick();
        check_eq("upd_owner", 64'(valo_s), 64'h12345678);
        val_s[96 +: 32] = 32'hFFFFFFFF;
        upd_s = 4'b1000;
        tick();
        check_eq("upd_other", 64'(valo_s), 64'h12345678);
        upd_s = 4'b0000;
        tick();

        // Owner 1 drops at dwell 3 with no other requester: idle, value held.
        req_s = 4'b0000;
        tick();
        check_dark("drop");
        check_eq("drop_val",   64'(valo_s),  64'h12345678);
        check_eq("drop_owner", 64'(owner_s), 64'h1);

        // Pending requester 2 drops mid-gap; re-pick to 3 only at gap end.
        req_s = 4'b0100;
        tick();
        req_s = 4'b1000;
        tick();
        check_dark("rp_b1");
        tick();
        check_dark("rp_b2");
        tick();
        check_dark("rp_b3");
        tick();
        check_own("repick", 4'b1000, 2'd3, 32'hFFFFFFFF);

        // Asynchronous reset between edges while owning.
        rst_s = 1'b1;
        #1;
        check_dark("arst");
        check_eq("arst_val",   64'(valo_s),  64'h0);
        check_eq("arst_owner", 64'(owner_s), 64'h0);
        #1;
        rst_s = 1'b0;
        req_s = 4'b1001;
        tick();
        check_dark("post_b");
        tick();
        tick();
        check_own("post_own", 4'b0001, 2'd0, 32'hA0A0A0A0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
